// File: rtl/gate_resp_checker.sv
// -----------------------------------------------------------------------------
// gate_resp_checker
//
// Purpose:
//   Response checker for a 2-input gate under test. It watches the gate
//   inputs {a,b} and its output y. It waits until {a,b} has been stable for
//   SETTLE clock edges, then compares y with the truth table TRUTH[{a,b}].
//   Each stable vector is checked once. The block counts checked vectors and
//   mismatches and records the first failing vector. It reports done/pass
//   once num_vec vectors have been checked.
//
// Parameters:
//   SETTLE  number of stable edges before a vector is sampled (1..255)
//   CNT_W   width of num_vec / vec_cnt / err_cnt
//   TRUTH   expected y indexed by {a,b} (4'b1000 AND, 4'b1110 OR, 4'b0110 XOR)
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle pulse that begins a run (ignored while busy)
//   num_vec          number of vectors to check, captured on start
//   a, b, y          gate inputs and gate output
//   busy             run in progress
//   done             run finished; held until the next accepted start
//   pass             done with no mismatches
//   vec_cnt          vectors checked in the current or last run
//   err_cnt          mismatches; saturates at all-ones
//   first_fail       {a,b,y} of the first mismatching vector
//   first_fail_vld   first_fail holds a captured vector
// -----------------------------------------------------------------------------
module gate_resp_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16,
  parameter logic [3:0]  TRUTH  = 4'b1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       first_fail,
  output logic             first_fail_vld
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // stab_cnt counts the edges a vector has already been stable; the sample
  // happens when it reaches SETTLE-1 on a further unchanged edge.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       first_fail_q, first_fail_d;
  logic             first_fail_vld_q, first_fail_vld_d;
  logic [1:0]       last_ab_q, last_ab_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             armed_q, armed_d;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic [1:0]       ab;
  logic             start_ok;
  logic             ab_changed;
  logic             sample_now;
  logic             mismatch;
  logic [CNT_W-1:0] vec_cnt_inc;
  logic             last_vec;

  assign ab          = {a, b};
  assign start_ok    = start && (state_q != ST_RUN);
  assign ab_changed  = (ab != last_ab_q);
  // An input change on this edge always wins over a maturing sample.
  assign sample_now  = (state_q == ST_RUN) && !ab_changed && armed_q &&
                       (stab_cnt_q == SETTLE_LAST);
  assign mismatch    = (y != TRUTH[ab]);
  assign vec_cnt_inc = vec_cnt_q + CNT_W'(1);
  assign last_vec    = (vec_cnt_inc == num_vec_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // An empty run completes immediately without ever going busy.
          state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (sample_now && last_vec) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    pass = (state_q == ST_DONE) && (err_cnt_q == '0);
  end

  assign vec_cnt        = vec_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    num_vec_d        = num_vec_q;
    vec_cnt_d        = vec_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
    last_ab_d        = last_ab_q;
    stab_cnt_d       = stab_cnt_q;
    armed_d          = armed_q;

    if (start_ok) begin
      num_vec_d        = num_vec;
      vec_cnt_d        = '0;
      err_cnt_d        = '0;
      first_fail_d     = 3'b000;
      first_fail_vld_d = 1'b0;
      // The vector present at the start edge counts as freshly applied.
      last_ab_d        = ab;
      stab_cnt_d       = 8'd0;
      armed_d          = (num_vec != '0);
    end else if (state_q == ST_RUN) begin
      if (ab_changed) begin
        last_ab_d  = ab;
        stab_cnt_d = 8'd0;
        armed_d    = 1'b1;
      end else if (sample_now) begin
        armed_d   = 1'b0;
        vec_cnt_d = vec_cnt_inc;
        if (mismatch) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (!first_fail_vld_q) begin
            first_fail_d     = {a, b, y};
            first_fail_vld_d = 1'b1;
          end
        end
      end else if (armed_q) begin
        stab_cnt_d = stab_cnt_q + 8'd1;
      end
      // Disarmed and unchanged: the vector was already checked, hold.
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_vec_q        <= '0;
      vec_cnt_q        <= '0;
      err_cnt_q        <= '0;
      first_fail_q     <= 3'b000;
      first_fail_vld_q <= 1'b0;
      last_ab_q        <= 2'b00;
      stab_cnt_q       <= 8'd0;
      armed_q          <= 1'b0;
    end else begin
      num_vec_q        <= num_vec_d;
      vec_cnt_q        <= vec_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
      last_ab_q        <= last_ab_d;
      stab_cnt_q       <= stab_cnt_d;
      armed_q          <= armed_d;
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_resp_checker
//
// Directed bench for gate_resp_checker with the default AND table and
// SETTLE=2. The gate under test is modelled by a continuous assignment:
// a correct AND, or a faulty OR when fault=1. Inputs are driven 1 ns after
// the rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_gate_resp_checker;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             a;
  logic             b;
  logic             y;
  logic             fault;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       first_fail;
  logic             first_fail_vld;

  int checks;
  int errors;

  logic [1:0] seq [4];

  assign y = fault ? (a | b) : (a & b);

  gate_resp_checker #(
    .SETTLE(2),
    .CNT_W (CNT_W),
    .TRUTH (4'b1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_vec       (num_vec),
    .a             (a),
    .b             (b),
    .y             (y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .vec_cnt       (vec_cnt),
    .err_cnt       (err_cnt),
    .first_fail    (first_fail),
    .first_fail_vld(first_fail_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs the 00,10,11,01 sequence with start on the first vector; each vector
  // is held 3 cycles and must be sampled exactly 2 edges after it appears.
  task automatic run_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      {a, b} = seq[i];
      if (i == 0) begin
        num_vec = 16'd4;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
      end else begin
        cyc();
      end
      checks++;
      if (vec_cnt !== CNT_W'(i)) begin
        errors++;
        $display("FAIL %s_apply%0d vec_cnt: got %0d expected %0d", tag, i, vec_cnt, i);
      end
      cyc();
      checks++;
      if (vec_cnt !== CNT_W'(i)) begin
        errors++;
        $display("FAIL %s_edge1_%0d vec_cnt: got %0d expected %0d", tag, i, vec_cnt, i);
      end
      cyc();
      checks++;
      if (vec_cnt !== CNT_W'(i + 1)) begin
        errors++;
        $display("FAIL %s_edge2_%0d vec_cnt: got %0d expected %0d", tag, i, vec_cnt, i + 1);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, pass, first_fail_vld} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/pass/ffv=%b expected 0000", {busy, done, pass, first_fail_vld});
    end
    checks++;
    if (vec_cnt !== 16'd0 || err_cnt !== 16'd0 || first_fail !== 3'b000) begin
      errors++;
      $display("FAIL reset_counts: got vec=%0d err=%0d ff=%b expected 0 0 000", vec_cnt, err_cnt, first_fail);
    end
    $display("test_reset: busy=%b done=%b vec=%0d err=%0d", busy, done, vec_cnt, err_cnt);
  endtask

  task automatic test_and_correct();
    fault = 1'b0;
    run_seq("and");
    checks++;
    if (vec_cnt !== 16'd4 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL and_counts: got vec=%0d err=%0d expected 4 0", vec_cnt, err_cnt);
    end
    checks++;
    if ({busy, done, pass, first_fail_vld} !== 4'b0110) begin
      errors++;
      $display("FAIL and_flags: got busy/done/pass/ffv=%b expected 0110", {busy, done, pass, first_fail_vld});
    end
    $display("test_and_correct: vec=%0d err=%0d done=%b pass=%b", vec_cnt, err_cnt, done, pass);
  endtask

  task automatic test_faulty();
    fault = 1'b1;
    run_seq("or");
    checks++;
    if (vec_cnt !== 16'd4 || err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL or_counts: got vec=%0d err=%0d expected 4 2", vec_cnt, err_cnt);
    end
    checks++;
    if ({done, pass} !== 2'b10) begin
      errors++;
      $display("FAIL or_done_pass: got %b expected 10", {done, pass});
    end
    checks++;
    if (first_fail !== 3'b101 || first_fail_vld !== 1'b1) begin
      errors++;
      $display("FAIL or_first_fail: got ff=%b vld=%b expected 101 1", first_fail, first_fail_vld);
    end
    $display("test_faulty: vec=%0d err=%0d first_fail=%b pass=%b", vec_cnt, err_cnt, first_fail, pass);
    fault = 1'b0;
  endtask

  task automatic test_short_vector();
    {a, b}  = 2'b00;
    num_vec = 16'd1;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL short_start: got busy/done=%b expected 10", {busy, done});
    end
    {a, b} = 2'b11;
    cyc();
    cyc();
    checks++;
    if (vec_cnt !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL short_not_yet: got vec=%0d done=%b expected 0 0", vec_cnt, done);
    end
    cyc();
    checks++;
    if (vec_cnt !== 16'd1 || done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL short_done: got vec=%0d done=%b pass=%b expected 1 1 1", vec_cnt, done, pass);
    end
    $display("test_short_vector: vec=%0d done=%b", vec_cnt, done);
  endtask

  task automatic test_long_hold();
    {a, b}  = 2'b11;
    num_vec = 16'd2;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (i == 5) begin
        start   = 1'b1;
        num_vec = 16'd7;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    start = 1'b0;
    checks++;
    if (vec_cnt !== 16'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL long_hold: got vec=%0d busy=%b done=%b expected 1 1 0", vec_cnt, busy, done);
    end
    {a, b} = 2'b01;
    cyc();
    cyc();
    cyc();
    checks++;
    if (vec_cnt !== 16'd2 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL long_second: got vec=%0d done=%b busy=%b expected 2 1 0", vec_cnt, done, busy);
    end
    $display("test_long_hold: vec=%0d busy=%b done=%b", vec_cnt, busy, done);
  endtask

  task automatic test_zero_vec();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pre_done: got %b expected 0", done);
    end
    num_vec = 16'd0;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    checks++;
    if ({busy, done, pass} !== 3'b011 || vec_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_done: got busy/done/pass=%b vec=%0d expected 011 0", {busy, done, pass}, vec_cnt);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_hold: got busy=%b done=%b expected 0 1", busy, done);
    end
    $display("test_zero_vec: busy=%b done=%b pass=%b", busy, done, pass);
  endtask

  task automatic test_reset_mid_run();
    fault   = 1'b1;
    {a, b}  = 2'b00;
    num_vec = 16'd4;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    cyc();
    cyc();
    {a, b} = 2'b10;
    cyc();
    cyc();
    cyc();
    checks++;
    if (vec_cnt !== 16'd2 || err_cnt !== 16'd1 || first_fail_vld !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_before_rst: got vec=%0d err=%0d ffv=%b busy=%b expected 2 1 1 1",
               vec_cnt, err_cnt, first_fail_vld, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, first_fail_vld} !== 4'b0000 || vec_cnt !== 16'd0 ||
        err_cnt !== 16'd0 || first_fail !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_rst: got flags=%b vec=%0d err=%0d ff=%b expected 0000 0 0 000",
               {busy, done, pass, first_fail_vld}, vec_cnt, err_cnt, first_fail);
    end
    cyc();
    rst   = 1'b0;
    fault = 1'b0;
    run_seq("rerun");
    checks++;
    if (vec_cnt !== 16'd4 || {done, pass} !== 2'b11 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rerun_done: got vec=%0d done/pass=%b err=%0d expected 4 11 0", vec_cnt, {done, pass}, err_cnt);
    end
    $display("test_reset_mid_run: vec=%0d done=%b pass=%b", vec_cnt, done, pass);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    seq[0]  = 2'b00;
    seq[1]  = 2'b10;
    seq[2]  = 2'b11;
    seq[3]  = 2'b01;
    rst     = 1'b1;
    start   = 1'b0;
    num_vec = '0;
    a       = 1'b0;
    b       = 1'b0;
    fault   = 1'b0;
    #2;
    test_reset();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    test_and_correct();
    test_faulty();
    test_short_vector();
    test_long_hold();
    test_zero_vec();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Synthesizable response checker: the receiving end of the gate stimulus/response path.
- A stimulus source drives a 2-input gate DUT. This block watches the DUT inputs a and b and the output y.
- After each input vector settles, it compares y with a parameterised truth table and counts checked vectors and mismatches.
- It records the first failing vector and reports pass/fail once a programmed number of vectors has been checked.

Parameters:
- SETTLE, 2: consecutive stable clock edges required before a vector is sampled. Legal range 1..255.
- CNT_W, 16: width of num_vec, vec_cnt and err_cnt.
- TRUTH, 4'b1000: expected y, indexed by {a,b}. 4'b1000 is AND; 4'b1110 is OR; 4'b0110 is XOR.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a check run. Ignored while busy=1.
- num_vec  input  CNT_W  number of vectors to check. Captured on start.
- a  input  1  DUT input a, same clock domain as clk.
- b  input  1  DUT input b, same clock domain as clk.
- y  input  1  DUT output.
- busy  output  1  high while a run is in progress.
- done  output  1  high from end of run until the next accepted start.
- pass  output  1  done & (err_cnt==0).
- vec_cnt  output  CNT_W  number of vectors checked in the current or last run.
- err_cnt  output  CNT_W  number of mismatches; saturates at all-ones.
- first_fail  output  3  {a,b,y} of the first mismatching vector.
- first_fail_vld  output  1  high once first_fail has been captured.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; busy=0, done=0, pass=0.
  - vec_cnt=0, err_cnt=0, first_fail=3'b000, first_fail_vld=0.
  - Internal last_ab=2'b00, stab_cnt=0, armed=0.
  - Asserting reset mid-run aborts the run immediately with no partial done.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Clear vec_cnt, err_cnt, first_fail, first_fail_vld and done.
  - Capture num_vec and set last_ab={a,b}, stab_cnt=0.
  - If the captured num_vec==0, go to DONE on the next edge (busy stays 0; done=1, pass=1 one cycle after start).
  - Otherwise set armed=1 and busy=1, and enter RUN.
- RUN, each rising edge, in priority order:
  1. {a,b}!=last_ab: last_ab<={a,b}, stab_cnt<=0, armed<=1. No sample on this edge, even if the previous vector would have matured on it.
  2. armed=1 and stab_cnt==SETTLE-1: sample the vector.
     - armed<=0; vec_cnt+1.
     - If y!=TRUTH[{a,b}]: err_cnt+1 (saturating). If first_fail_vld=0, capture first_fail<={a,b,y} and set first_fail_vld<=1.
     - If the new vec_cnt equals the captured num_vec: busy<=0, done<=1, state DONE.
  3. armed=1 otherwise: stab_cnt+1.
  4. armed=0 (vector already checked and unchanged): hold. A vector is sampled at most once.
- Latency: a vector applied before edge k, and stable from then on, is sampled on edge k+SETTLE. Its counters are visible after that edge.
- y is not used for stability detection; only {a,b} changes re-arm the checker. A y glitch before the sample edge is not recorded.
- DONE holds all results until the next start or reset. start in DONE begins a new run.
- start while busy=1 has no effect. num_vec changes during RUN have no effect.

Test Plan:
- AND table, SETTLE=2, num_vec=4, correct gate:
  - Stimulus: apply (a,b)=00,10,11,01, each held 3 cycles.
  - Required: vec_cnt=4, err_cnt=0, done=1, pass=1, first_fail_vld=0.
  - Each vector is sampled exactly 2 edges after it is applied.
- Faulty DUT modelled as y=a|b, num_vec=4, same sequence:
  - Required: err_cnt=2, pass=0.
  - first_fail=3'b101 (a=1,b=0,y=1), first_fail_vld=1.
- Vector held only 1 cycle with SETTLE=2 (00 for 1 cycle, then 11 for 3 cycles), num_vec=1:
  - 00 is never sampled; 11 is sampled.
  - Required: vec_cnt=1 at done.
- Vector held 10 cycles, num_vec=2:
  - Sampled once only; vec_cnt stays 1 and busy stays 1 until a second vector settles.
  - start pulsed mid-run is ignored (vec_cnt is not cleared).
- num_vec=0:
  - start -> done=1, pass=1 one cycle later; busy never asserted.
- rst asserted mid-run after 2 of 4 vectors:
  - All outputs return to reset values asynchronously (before the next clk edge).
  - A new start completes a full 4-vector run normally.
